// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern demos: mode codes, PWM period,
// bounce direction and the per-mode reset/reload pattern.
package led_pkg;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    localparam int PWM_PERIOD = 15;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Starting pattern for a mode; callers keep the low n_led bits.
    function automatic logic [31:0] seed(input logic [1:0] mode, input int n_led);
        logic [31:0] ones;
        ones = (n_led >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n_led) - 32'd1);
        case (mode)
            MODE_BLINK:            seed = ones;
            MODE_RUN, MODE_BOUNCE: seed = 32'd1;
            default:               seed = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: raises tick combinationally on the cycle a step is due, so
// the caller registers its pulse and advances its state on the same edge.
module led_tick_gen #(
    parameter int BASE_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] speed,
    input  logic       clear,
    output logic       tick
);

    localparam int CNT_W = $clog2(BASE_DIV + 1);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

    if (BASE_DIV < 8) begin : g_bad_div
        $error("led_tick_gen: BASE_DIV must be at least 8");
    end

    logic [CNT_W-1:0] prescaler_q;
    logic [CNT_W-1:0] prescaler_d;
    logic [CNT_W-1:0] div_m1;

    // ">=" rather than "==" so a speed increase mid-count fires on the next edge.
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        div_m1      = (BASE >> speed) - CNT_W'(1);
        tick        = en && !clear && (prescaler_q >= div_m1);
        prescaler_d = prescaler_q;
        if (clear || tick) begin
            prescaler_d = '0;
        end else if (en) begin
            prescaler_d = prescaler_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED driver: blink/run/bounce/count patterns stepped by a
// prescaler, gated by a 15-clock PWM and registered onto the pins.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED   = 8,
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic [3:0]       bright,
    output logic [N_LED-1:0] led,
    output logic             step_tick
);

    localparam int BASE_DIV = CLK_HZ / STEP_HZ;

    if (N_LED < 2 || N_LED > 32) begin : g_bad_n_led
        $error("led_pattern_gen: N_LED must be in 2..32");
    end

    logic [1:0]       mode_q,      mode_d;
    logic [N_LED-1:0] pattern_q,   pattern_d;
    dir_e             dir_q,       dir_d;
    logic             step_tick_q, step_tick_d;
    logic [3:0]       pwm_cnt_q,   pwm_cnt_d;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] seed_new;
    logic             reload;
    logic             tick;
    logic             pwm_on;

    assign seed_new = N_LED'(seed(mode, N_LED));
    assign reload   = (mode != mode_q);

    led_tick_gen #(
        .BASE_DIV (BASE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .speed (speed),
        .clear (reload),
        .tick  (tick)
    );

    // A mode change reloads the seed and suppresses any step due on that edge.
    always_comb begin
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        dir_d       = dir_q;
        step_tick_d = 1'b0;
        if (reload) begin
            mode_d    = mode;
            pattern_d = seed_new;
            dir_d     = DIR_LEFT;
        end else if (tick) begin
            step_tick_d = 1'b1;
            case (mode_q)
                MODE_BLINK: pattern_d = ~pattern_q;
                MODE_RUN:   pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                MODE_BOUNCE: begin
                    // Turn around at either end without repeating the end position.
                    if (dir_q == DIR_LEFT) begin
                        if (pattern_q[N_LED-1]) begin
                            dir_d     = DIR_RIGHT;
                            pattern_d = pattern_q >> 1;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            dir_d     = DIR_LEFT;
                            pattern_d = pattern_q << 1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                default:    pattern_d = pattern_q + N_LED'(1);
            endcase
        end
    end

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == 4'(PWM_PERIOD - 1)) ? 4'd0 : pwm_cnt_q + 4'd1;
        pwm_on    = (bright == 4'd15) || (pwm_cnt_q < bright);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= mode;
            pattern_q   <= seed_new;
            dir_q       <= DIR_LEFT;
            step_tick_q <= 1'b0;
            pwm_cnt_q   <= 4'd0;
            led_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            dir_q       <= dir_d;
            step_tick_q <= step_tick_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= pattern_q & {N_LED{pwm_on}};
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: a reset/blink vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_led_pattern_gen;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i = 1'b1;
    logic [1:0] mode_i = 2'd0;
    logic [1:0] speed_i = 2'd0;
    logic [3:0] bright_i = 4'd15;
    logic [N-1:0] led;
    logic       step_tick;

    int checks = 0;
    int failures = 0;

    led_pattern_gen #(
        .N_LED   (N),
        .CLK_HZ  (32),
        .STEP_HZ (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n_i),
        .en        (en_i),
        .mode      (mode_i),
        .speed     (speed_i),
        .bright    (bright_i),
        .led       (led),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    // Behavioural model: pattern held as an abstract position/value per mode.
    int   m_mode, m_pos, m_dir, m_count, m_pres, m_pwm;
    bit   m_blink_on, m_tick;
    logic [7:0] m_led;

    function automatic logic [7:0] m_pattern();
        case (m_mode)
            0:       return m_blink_on ? 8'hFF : 8'h00;
            1, 2:    return 8'(32'd1 << m_pos);
            default: return 8'(m_count);
        endcase
    endfunction

    task automatic m_seed(input int md);
        m_mode = md; m_blink_on = 1'b1; m_pos = 0; m_dir = 1; m_count = 0;
    endtask

    task automatic m_advance();
        case (m_mode)
            0: m_blink_on = !m_blink_on;
            1: m_pos = (m_pos + 1) % N;
            2: begin
                m_pos = m_pos + m_dir;
                if (m_pos == N)  begin m_pos = N - 2; m_dir = -1; end
                if (m_pos == -1) begin m_pos = 1;     m_dir = 1;  end
            end
            default: m_count = (m_count + 1) % 256;
        endcase
    endtask

    task automatic model_edge();
        logic [7:0] nxt_led;
        int div;
        if (!rst_n_i) begin
            m_seed(int'(mode_i));
            m_pres = 0; m_pwm = 0; m_tick = 1'b0; m_led = 8'h00;
            return;
        end
        nxt_led = (bright_i == 4'd15 || m_pwm < int'(bright_i)) ? m_pattern() : 8'h00;
        m_pwm   = (m_pwm + 1) % 15;
        m_tick  = 1'b0;
        if (int'(mode_i) != m_mode) begin
            m_seed(int'(mode_i));
            m_pres = 0;
        end else if (en_i) begin
            div = 8 >> speed_i;
            if (m_pres >= div - 1) begin
                m_pres = 0; m_tick = 1'b1; m_advance();
            end else begin
                m_pres++;
            end
        end
        m_led = nxt_led;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: DUT and model see the same inputs; outputs compared 1 time unit later.
    task automatic cyc(input bit use_model);
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) begin
            check("led_vs_model", {24'd0, led}, {24'd0, m_led});
            check("tick_vs_model", {31'd0, step_tick}, {31'd0, m_tick});
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [1:0] speed;
        logic [3:0] bright;
        logic [7:0] exp_led;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] prev, held;
        int cnt_hi, cnt_a, cnt_b, n_ticks, k;
        bit seen;

        // Reset then BLINK at speed 0: 00 for one cycle, FF for 8, pulse on the 8th.
        vecs[0] = '{1'b0, 1'b1, 2'd0, 2'd0, 4'd15, 8'h00, 1'b0};
        for (int i = 1; i <= 7; i++) vecs[i] = '{1'b1, 1'b1, 2'd0, 2'd0, 4'd15, 8'hFF, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 2'd0, 4'd15, 8'hFF, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 2'd0, 4'd15, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'd0, 2'd0, 4'd15, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd0, 2'd0, 4'd15, 8'h00, 1'b0};

        #2;
        for (int i = 0; i < 12; i++) begin
            rst_n_i = vecs[i].rst_n; en_i = vecs[i].en; mode_i = vecs[i].mode;
            speed_i = vecs[i].speed; bright_i = vecs[i].bright;
            cyc(1'b0);
            check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
            check($sformatf("vec%0d_tick", i), {31'd0, step_tick}, {31'd0, vecs[i].exp_tick});
        end
        // Remaining BLINK period: 00 through edge 16 (tick there), FF from edge 17.
        for (int i = 12; i <= 17; i++) cyc(1'b1);
        check("blink_back_on", {24'd0, led}, 32'hFF);

        // RUN at div=2: verify 80 -> 01 wrap and one step per 2 clocks.
        mode_i = 2'd1; speed_i = 2'd2;
        cyc(1'b1);
        seen = 1'b0; n_ticks = 0; prev = led;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1);
            if (prev == 8'h80 && led == 8'h01) seen = 1'b1;
            if (step_tick) n_ticks++;
            prev = led;
        end
        check("run_wrap_80_01", {31'd0, seen}, 32'd1);
        check("run_tick_count", n_ticks, 20);

        // BOUNCE at div=1: each end appears exactly once per 14-step turn.
        mode_i = 2'd2; speed_i = 2'd3;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1);
            if (led == 8'h80) cnt_a++;
            if (led == 8'h01) cnt_b++;
        end
        check("bounce_80_once", cnt_a, 1);
        check("bounce_01_once", cnt_b, 1);

        // COUNT with a 20-cycle freeze in the middle; wrap FF -> 00 must occur.
        mode_i = 2'd3; speed_i = 2'd3;
        cyc(1'b1);
        seen = 1'b0; prev = led;
        for (int i = 0; i < 130; i++) begin
            cyc(1'b1);
            if (prev == 8'hFF && led == 8'h00) seen = 1'b1;
            prev = led;
        end
        en_i = 1'b0;
        n_ticks = 0;
        cyc(1'b1);
        if (step_tick) n_ticks++;
        cyc(1'b1);
        if (step_tick) n_ticks++;
        held = led;
        cnt_a = 0;
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1);
            if (step_tick) n_ticks++;
            if (led != held) cnt_a++;
        end
        check("freeze_no_tick", n_ticks, 0);
        check("freeze_led_held", cnt_a, 0);
        en_i = 1'b1;
        cyc(1'b1);
        check("resume_from_held", {24'd0, led}, {24'd0, held});
        prev = led;
        for (int i = 0; i < 140; i++) begin
            cyc(1'b1);
            if (prev == 8'hFF && led == 8'h00) seen = 1'b1;
            prev = led;
        end
        check("count_wrap_ff_00", {31'd0, seen}, 32'd1);

        // PWM on a frozen all-ones BLINK pattern.
        en_i = 1'b0; mode_i = 2'd0; bright_i = 4'd5;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        cnt_hi = 0; cnt_a = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1);
            if (led == 8'hFF) cnt_hi++;
            else if (led != 8'h00) cnt_a++;
        end
        check("pwm5_high_count", cnt_hi, 5);
        check("pwm5_other_values", cnt_a, 0);
        bright_i = 4'd0;
        cyc(1'b1);
        cnt_a = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1);
            if (led != 8'h00) cnt_a++;
        end
        check("pwm0_always_off", cnt_a, 0);
        bright_i = 4'd15;
        cyc(1'b1);
        cnt_a = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1);
            if (led != 8'hFF) cnt_a++;
        end
        check("pwm15_always_on", cnt_a, 0);

        // RUN -> COUNT on the very cycle a step is due.
        en_i = 1'b1; mode_i = 2'd1; speed_i = 2'd0;
        cyc(1'b1);
        k = 0;
        while (m_pres != 7 && k < 20) begin
            cyc(1'b1);
            k++;
        end
        check("step_due_reached", {31'd0, m_pres == 7}, 32'd1);
        mode_i = 2'd3;
        cyc(1'b1);
        check("reload_no_tick", {31'd0, step_tick}, 32'd0);
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1);
            if (i == 1) check("reload_led_00", {24'd0, led}, 32'd0);
            if (step_tick && k == 0) k = i;
        end
        check("first_step_after_reload", k, 8);

        // Reset in the middle of a BOUNCE sweep.
        mode_i = 2'd2; speed_i = 2'd3;
        for (int i = 0; i < 5; i++) cyc(1'b1);
        rst_n_i = 1'b0;
        cyc(1'b1);
        check("midreset_led", {24'd0, led}, 32'd0);
        check("midreset_tick", {31'd0, step_tick}, 32'd0);
        rst_n_i = 1'b1;
        cyc(1'b1);
        check("midreset_seed_led", {24'd0, led}, 32'h01);

        // Randomized operation against the model.
        for (int i = 0; i < 800; i++) begin
            en_i = ($urandom_range(7) != 0);
            if ($urandom_range(39) == 0) mode_i = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) speed_i = 2'($urandom_range(3));
            if ($urandom_range(19) == 0) bright_i = 4'($urandom_range(15));
            rst_n_i = ($urandom_range(199) != 0);
            cyc(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
